fpa_arbiter: RTL
================

Name: fpa_arbiter

Overview:
Shares one floating-point adder (EXP_WIDTH=8, MANTISSA_WIDTH=23, 32-bit operands) among N_REQ requesters. Each requester presents operand pairs through a valid/ready handshake. The arbiter picks one requester per cycle by round-robin and issues its operands to the adder. It tags each issued operation in an in-order FIFO and routes each adder result back to the requester that issued it. It sits between requesters and the fpa datapath, which has a fixed but unknown latency.

Parameters:
EXP_WIDTH, 8, exponent width
MANTISSA_WIDTH, 23, mantissa width; WIDTH = 1+EXP_WIDTH+MANTISSA_WIDTH
N_REQ, 4, number of requesters (2..8)
MAX_INFLIGHT, 4, tag FIFO depth and maximum number of outstanding adder ops (power of 2)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid_i  in  N_REQ  per-requester operand valid
req_ready_o  out  N_REQ  one-hot grant; handshake when valid&ready
req_a_i  in  N_REQ*WIDTH  operand A; requester k uses bits [k*WIDTH +: WIDTH]
req_b_i  in  N_REQ*WIDTH  operand B, same packing
fpa_valid_o  out  1  issue strobe to adder
fpa_a_o  out  WIDTH  operand A to adder
fpa_b_o  out  WIDTH  operand B to adder
fpa_valid_i  in  1  adder result valid; results return in issue order
fpa_result_i  in  WIDTH  adder result
rsp_valid_o  out  N_REQ  one-hot result strobe
rsp_result_o  out  WIDTH  result data
inflight_o  out  log2(MAX_INFLIGHT)+1  outstanding op count
err_o  out  1  sticky: result arrived with no op outstanding

Behaviour:
- Reset, asynchronous on rst_n low:
  - All outputs 0.
  - Round-robin pointer = 0.
  - Tag FIFO empty, inflight = 0, err_o = 0.
  - Reset mid-operation discards all outstanding tags. Any later fpa_valid_i sets err_o.
- Issue is allowed when inflight < MAX_INFLIGHT. There is no same-cycle bypass when a result pops while the FIFO is full.
- Grant (combinational):
  - If issue is allowed, req_ready_o[k]=1 for the first k with req_valid_i[k]=1, searching ptr, ptr+1, … mod N_REQ.
  - Otherwise req_ready_o = 0.
  - req_ready_o never depends on anything except req_valid_i, ptr and inflight.
- On handshake at cycle T:
  - fpa_valid_o=1 and fpa_a_o/fpa_b_o hold the granted operands at T+1 (registered).
  - Tag k is pushed into the FIFO.
  - ptr becomes (k+1) mod N_REQ.
  - fpa_valid_o is a single-cycle pulse. fpa_a_o/fpa_b_o hold their last value when not valid.
- On fpa_valid_i at cycle T with FIFO non-empty:
  - The head tag t is popped.
  - rsp_valid_o = (1<<t) and rsp_result_o = fpa_result_i at T+1, one cycle of registered latency.
  - Requesters cannot back-pressure results.
- On fpa_valid_i at cycle T with FIFO empty:
  - err_o becomes 1 at T+1 and stays until reset.
  - No rsp_valid_o pulse; the FIFO is unchanged.
- inflight update:
  - Handshake and pop in the same cycle: count unchanged.
  - Handshake only: +1.
  - Pop only: −1.
  - inflight_o is registered.
- FIFO pointers wrap modulo MAX_INFLIGHT.
- Idle requesters never hold the pointer; ptr moves only on a handshake.
- Operand values are passed unmodified; the arbiter performs no arithmetic on data.

Test Plan:
- Bench adder model is a 3-cycle pipeline.
- Single request: req0 valid with a=0x3F800000 (1.0), b=0x40000000 (2.0) → req_ready_o=0001 same cycle; fpa_valid_o at +1; rsp_valid_o=0001 with rsp_result_o=0x40400000 (3.0) at +5; inflight_o goes 0→1→0.
- Fairness: all 4 requesters held valid continuously → grant sequence 0,1,2,3,0,1 … each cycle while inflight<4; each rsp_valid_o bit receives results in that order.
- Saturation: adder model delays results by 10 cycles with all 4 requesters valid → exactly 4 issues, then req_ready_o=0 until the first result; inflight_o peaks at 4 and never exceeds it.
- Simultaneous push/pop: at inflight=2, a handshake in the same cycle as fpa_valid_i → inflight_o stays 2; the returned tag matches the oldest issue.
- Spurious result: fpa_valid_i asserted after reset with nothing issued → err_o=1 next cycle and stays 1; rsp_valid_o remains 0.
- Reset mid-operation: 3 ops outstanding, pulse rst_n low → all outputs 0, ptr=0; the next grant goes to the lowest valid requester; late adder results set err_o.

Source files
------------

// File: rtl/fpa_arbiter.sv
// Round-robin arbiter sharing one floating-point adder among N_REQ requesters.
// An in-order tag FIFO routes each adder result back to the requester that issued it.
module fpa_arbiter #(
    parameter int EXP_WIDTH      = 8,
    parameter int MANTISSA_WIDTH = 23,
    parameter int N_REQ          = 4,
    parameter int MAX_INFLIGHT   = 4,
    localparam int WIDTH         = 1 + EXP_WIDTH + MANTISSA_WIDTH,
    localparam int CNT_W         = $clog2(MAX_INFLIGHT) + 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid_i,
    output logic [N_REQ-1:0]       req_ready_o,
    input  logic [N_REQ*WIDTH-1:0] req_a_i,
    input  logic [N_REQ*WIDTH-1:0] req_b_i,
    output logic                   fpa_valid_o,
    output logic [WIDTH-1:0]       fpa_a_o,
    output logic [WIDTH-1:0]       fpa_b_o,
    input  logic                   fpa_valid_i,
    input  logic [WIDTH-1:0]       fpa_result_i,
    output logic [N_REQ-1:0]       rsp_valid_o,
    output logic [WIDTH-1:0]       rsp_result_o,
    output logic [CNT_W-1:0]       inflight_o,
    output logic                   err_o
);

    localparam int TAG_W = $clog2(N_REQ);
    localparam int PTR_W = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;

    logic [TAG_W-1:0] r_ptr;
    logic [CNT_W-1:0] r_count;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [TAG_W-1:0] r_tags [MAX_INFLIGHT];
    logic             r_fpa_valid;
    logic [WIDTH-1:0] r_fpa_a;
    logic [WIDTH-1:0] r_fpa_b;
    logic [N_REQ-1:0] r_rsp_valid;
    logic [WIDTH-1:0] r_rsp_result;
    logic             r_err;

    logic             w_issue_ok;
    logic             w_hs;
    logic [N_REQ-1:0] w_grant;
    logic [TAG_W-1:0] w_grant_idx;
    logic [TAG_W-1:0] w_ptr_next;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic             w_pop;
    logic             w_err_set;
    logic [TAG_W-1:0] w_head_tag;
    logic [N_REQ-1:0] w_rsp_onehot;

    assign w_issue_ok = (r_count < CNT_W'(MAX_INFLIGHT));

    // Search ptr, ptr+1, ... and grant the first valid requester.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
        w_grant     = '0;
        w_grant_idx = '0;
        w_hs        = 1'b0;
        if (w_issue_ok) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!w_hs && req_valid_i[(int'(r_ptr) + i) % N_REQ]) begin
                    w_hs                                   = 1'b1;
                    w_grant_idx                            = TAG_W'((int'(r_ptr) + i) % N_REQ);
                    w_grant[(int'(r_ptr) + i) % N_REQ]     = 1'b1;
                end
            end
        end
    end

    assign w_ptr_next   = (w_grant_idx == TAG_W'(N_REQ - 1)) ? '0 : w_grant_idx + 1'b1;
    assign w_a          = req_a_i[int'(w_grant_idx) * WIDTH +: WIDTH];
    assign w_b          = req_b_i[int'(w_grant_idx) * WIDTH +: WIDTH];
    assign w_pop        = fpa_valid_i && (r_count != '0);
    assign w_err_set    = fpa_valid_i && (r_count == '0);
    assign w_head_tag   = r_tags[r_rd_ptr];
    assign w_rsp_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << w_head_tag;

    // NOTE: tag storage has no reset; r_count alone decides which entries are live, so stale tags are never read.
    always_ff @(posedge clk) begin
        if (w_hs) begin
            r_tags[r_wr_ptr] <= w_grant_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr        <= '0;
            r_count      <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_fpa_valid  <= 1'b0;
            r_fpa_a      <= '0;
            r_fpa_b      <= '0;
            r_rsp_valid  <= '0;
            r_rsp_result <= '0;
            r_err        <= 1'b0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
            r_fpa_valid <= w_hs;
            if (w_hs) begin
                r_fpa_a  <= w_a;
                r_fpa_b  <= w_b;
                r_ptr    <= w_ptr_next;
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rsp_valid  <= w_rsp_onehot;
                r_rsp_result <= fpa_result_i;
                r_rd_ptr     <= r_rd_ptr + 1'b1;
            end else begin
                r_rsp_valid  <= '0;
            end
            if (w_err_set) begin
                r_err <= 1'b1;
            end
            case ({w_hs, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign req_ready_o  = w_grant;
    assign fpa_valid_o  = r_fpa_valid;
    assign fpa_a_o      = r_fpa_a;
    assign fpa_b_o      = r_fpa_b;
    assign rsp_valid_o  = r_rsp_valid;
    assign rsp_result_o = r_rsp_result;
    assign inflight_o   = r_count;
    assign err_o        = r_err;

endmodule
